// File: rtl/idli_pkg.sv
// Shared idli definitions: SQI command/mode constants, field lengths and the
// SQI memory responder state type.
package idli_pkg;

   localparam logic [7:0] SQI_CMD_READ  = 8'h03;
   localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SQI_CMD_RDMR  = 8'h05;
   localparam logic [7:0] SQI_MODE_SEQ  = 8'h40;

   localparam int unsigned SQI_ADDR_NIBBLES  = 6;
   localparam int unsigned SQI_DUMMY_NIBBLES = 2;

   typedef enum logic [2:0] {
      SQI_IDLE,
      SQI_CMD,
      SQI_ADDR,
      SQI_DUMMY,
      SQI_RD_DATA,
      SQI_WR_DATA,
      SQI_ERR,
      SQI_RD_MODE
   } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_array_m.sv
// Byte array for the SQI memory responder: one synchronous write port and
// one combinational read port; contents are deliberately not reset.
module idli_sqi_mem_array_m #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data
);

   logic [7:0] mem_q [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes cmd/addr/dummy nibbles and streams byte data.
// Define IDLI_SQI_MEM_RDMR_EN to enable the RDMR (0x05) mode-register read.
//
// state       | meaning
// ------------+-----------------------------------------------
// SQI_IDLE    | deselected, waiting for cs low
// SQI_CMD     | shifting in the 2 command nibbles
// SQI_ADDR    | shifting in the 6 address nibbles
// SQI_DUMMY   | skipping the 2 dummy nibbles of a READ
// SQI_RD_DATA | driving mem[addr] hi/lo nibbles on sck falls
// SQI_WR_DATA | assembling bytes on sck rises, committing to mem
// SQI_ERR     | unknown command, ignore until cs high
// SQI_RD_MODE | driving the mode byte hi/lo on sck falls
module idli_sqi_mem_m
   import idli_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic       i_mem_gck,
   input  logic       i_mem_rst,
   input  logic       i_mem_sqi_sck,
   input  logic       i_mem_sqi_cs,
   input  logic [3:0] i_mem_sqi_data,
   output logic [3:0] o_mem_sqi_data,
   output logic       o_mem_sqi_oe
);

   sqi_mem_state_t    state_q, state_d;
   logic              sck_q, sck_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        wr_hi_q, wr_hi_d;
   logic [3:0]        dout_q, dout_d;
   logic              oe_q, oe_d;

   logic              rise, fall;
   logic              wr_en;
   logic [7:0]        wr_data;
   logic [7:0]        rd_data;

   assign sck_d = i_mem_sqi_sck;
   assign rise  = i_mem_sqi_sck & ~sck_q;
   assign fall  = ~i_mem_sqi_sck & sck_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wr_hi_d = wr_hi_q;
      dout_d  = dout_q;
      oe_d    = oe_q;
      wr_en   = 1'b0;
      wr_data = {wr_hi_q, i_mem_sqi_data};

      if (i_mem_sqi_cs) begin
         state_d = SQI_IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            SQI_IDLE: begin
               state_d = SQI_CMD;
               cnt_d   = '0;
            end
            SQI_CMD: begin
               if (rise) begin
                  cmd_d = {cmd_q[3:0], i_mem_sqi_data};
                  if (cnt_q == 3'd1) begin
                     cnt_d = '0;
                     if (cmd_d == SQI_CMD_READ || cmd_d == SQI_CMD_WRITE) begin
                        state_d = SQI_ADDR;
`ifdef IDLI_SQI_MEM_RDMR_EN
                     end else if (cmd_d == SQI_CMD_RDMR) begin
                        state_d = SQI_RD_MODE;
`endif
                     end else begin
                        state_d = SQI_ERR;
                     end
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            SQI_ADDR: begin
               if (rise) begin
                  // Only the low ADDR_W bits survive the shift.
                  addr_d = ADDR_W'({addr_q, i_mem_sqi_data});
                  if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
                     cnt_d   = '0;
                     state_d = (cmd_q == SQI_CMD_READ) ? SQI_DUMMY : SQI_WR_DATA;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            SQI_DUMMY: begin
               if (rise) begin
                  if (cnt_q == 3'(SQI_DUMMY_NIBBLES - 1)) begin
                     cnt_d   = '0;
                     state_d = SQI_RD_DATA;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            SQI_RD_DATA: begin
               if (fall) begin
                  oe_d = 1'b1;
                  if (!cnt_q[0]) begin
                     dout_d = rd_data[7:4];
                     cnt_d  = 3'd1;
                  end else begin
                     dout_d = rd_data[3:0];
                     cnt_d  = '0;
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
            SQI_WR_DATA: begin
               if (rise) begin
                  if (!cnt_q[0]) begin
                     wr_hi_d = i_mem_sqi_data;
                     cnt_d   = 3'd1;
                  end else begin
                     wr_en  = 1'b1;
                     cnt_d  = '0;
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
`ifdef IDLI_SQI_MEM_RDMR_EN
            SQI_RD_MODE: begin
               if (fall) begin
                  oe_d   = 1'b1;
                  dout_d = cnt_q[0] ? SQI_MODE_SEQ[3:0] : SQI_MODE_SEQ[7:4];
                  cnt_d  = {2'b00, ~cnt_q[0]};
               end
            end
`endif
            SQI_ERR: begin
               state_d = SQI_ERR;
            end
            default: begin
               state_d = SQI_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_mem_gck) begin
      if (i_mem_rst) begin
         state_q <= SQI_IDLE;
         sck_q   <= 1'b0;
         cnt_q   <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         wr_hi_q <= '0;
         dout_q  <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sck_q   <= sck_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wr_hi_q <= wr_hi_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
      end
   end

   idli_sqi_mem_array_m #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .i_clk     (i_mem_gck),
      .i_wr_en   (wr_en),
      .i_wr_addr (addr_q),
      .i_wr_data (wr_data),
      .i_rd_addr (addr_q),
      .o_rd_data (rd_data)
   );

   assign o_mem_sqi_data = dout_q;
   assign o_mem_sqi_oe   = oe_q;

endmodule
